inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
- Program loader that writes the instruction memory, which the pipeline only reads at PC.
- Accepts a framed byte stream on a valid/ready interface and assembles big-endian 32-bit words.
- Drives the instruction memory write port at byte addresses 0, 4, 8, ….
- Holds the CPU (cpuHold_LDR) from reset until a frame loads and its checksum verifies.

Parameters:
SYNC_BYTE, 8'hA5, frame start marker
MAX_WORDS, 64, maximum words per frame (256-byte instruction memory / 4)
BASE_ADDR, 8'h00, byte address of the first written word

Ports:
clk_LDR  input  1  clock, all state updates on rising edge
rst_LDR  input  1  reset: asynchronous, active-high
byteIn_LDR  input  8  stream data byte
byteValid_LDR  input  1  byteIn_LDR valid this cycle
byteReady_LDR  output  1  loader accepts byte; transfer occurs when valid && ready at clock edge
wEn_LDR  output  1  instruction memory write enable, one-cycle pulse per word
wAddr_LDR  output  8  instruction memory byte address
wData_LDR  output  32  instruction word
cpuHold_LDR  output  1  1 = CPU pipeline held (PC and buffers frozen)
done_LDR  output  1  last frame loaded and verified
error_LDR  output  1  last frame rejected
wordsLoaded_LDR  output  7  words written in current or last frame

Behaviour:
- Frame format: SYNC_BYTE, count N (1..MAX_WORDS), 4*N payload bytes (MSB first per word), checksum = 8-bit sum mod 256 of all payload bytes.
- Reset (async) values: state IDLE; cpuHold_LDR=1; byteReady_LDR=1; wEn_LDR=0; wAddr_LDR=BASE_ADDR; wData_LDR=0; done_LDR=0; error_LDR=0; wordsLoaded_LDR=0; internal byte index, word counter and checksum accumulator cleared.
- Reset asserted mid-frame aborts the frame immediately. Words already written stay in memory. The CPU stays held.
- byteReady_LDR is 1 in every state except WRITE.
- IDLE / DONE / ERR:
  - Accepted byte == SYNC_BYTE → COUNT. Same edge: cpuHold_LDR=1, done_LDR=0, error_LDR=0, wordsLoaded_LDR=0, accumulator=0, wAddr_LDR=BASE_ADDR.
  - Any other accepted byte is discarded; state unchanged.
- COUNT: accepted byte N.
  - N==0 or N>MAX_WORDS → ERR, error_LDR=1.
  - Otherwise latch N → DATA, byte index 0.
- DATA: each accepted byte shifts into the assembly register (first byte lands in [31:24]) and is added to the accumulator. On the 4th byte, wData_LDR is loaded with the assembled word → WRITE.
- WRITE (exactly 1 cycle, byteReady_LDR=0):
  - wEn_LDR=1 with the current wAddr_LDR and wData_LDR.
  - Next edge: wAddr_LDR += 4 (wraps mod 256), wordsLoaded_LDR += 1.
  - If wordsLoaded_LDR reaches N → CHECK, else → DATA.
- CHECK: accepted byte compared with the accumulator.
  - Equal → DONE: done_LDR=1, cpuHold_LDR=0 on that edge.
  - Unequal → ERR: error_LDR=1, cpuHold_LDR stays 1.
- wEn_LDR is asserted only in WRITE, never in any other state.
- A valid byte arriving while byteReady_LDR=0 is not consumed. The source must hold it stable until accepted.
- DONE re-arms on a new SYNC_BYTE. cpuHold_LDR rises on the sync edge, before any write occurs.
- Upper bound: a frame with N=MAX_WORDS writes through address BASE_ADDR+252 with no overflow into BASE_ADDR.
- Throughput: 5 cycles per word minimum (4 byte cycles + 1 WRITE cycle).

Test Plan:
- Reset, no stream → cpuHold_LDR=1, done_LDR=0, error_LDR=0, wEn_LDR=0, byteReady_LDR=1 held indefinitely.
- Stream A5 02 20 08 00 05 01 09 40 20 97 with valid every cycle:
  - Writes 0x20080005 @0x00, then 0x01094020 @0x04.
  - Each write is a single wEn_LDR pulse, with byteReady_LDR=0 in that cycle.
  - Then done_LDR=1, cpuHold_LDR=0, wordsLoaded_LDR=2.
- Same frame with checksum 0x98 → both words written, then error_LDR=1, cpuHold_LDR=1, done_LDR=0.
- Stream 00 33 A5 00 → leading junk ignored, count 0 → error_LDR=1, no wEn_LDR pulses. Following A5 01 00 00 00 00 00 → done_LDR=1, error_LDR cleared.
- Frame A5 02 + 6 bytes, then rst_LDR pulsed asynchronously mid-cycle → outputs return to reset values immediately. One write @0x00 already done. Next frame restarts at BASE_ADDR.
- Frame with N=64 and random valid gaps → 64 writes at 0x00..0xFC in order, done_LDR=1, wordsLoaded_LDR=64. N=65 → error_LDR=1 with no writes.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Framed byte-stream program loader: assembles big-endian words, writes the
// instruction memory, and holds the CPU until a frame's checksum verifies.
module inst_mem_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         MAX_WORDS = 64,
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic        clk_LDR,
    input  logic        rst_LDR,
    input  logic [7:0]  byteIn_LDR,
    input  logic        byteValid_LDR,
    output logic        byteReady_LDR,
    output logic        wEn_LDR,
    output logic [7:0]  wAddr_LDR,
    output logic [31:0] wData_LDR,
    output logic        cpuHold_LDR,
    output logic        done_LDR,
    output logic        error_LDR,
    output logic [6:0]  wordsLoaded_LDR
);

    typedef enum logic [2:0] {
        IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERR
    } state_t;

    localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

    state_t      state;
    logic [1:0]  byte_idx;
    logic [6:0]  n_words;
    logic [7:0]  acc;
    logic [23:0] asm_q;
    logic        take;

    assign take = byteValid_LDR && byteReady_LDR;

    always_ff @(posedge clk_LDR or posedge rst_LDR) begin
        if (rst_LDR) begin
            state           <= IDLE;
            cpuHold_LDR     <= 1'b1;
            byteReady_LDR   <= 1'b1;
            wEn_LDR         <= 1'b0;
            wAddr_LDR       <= BASE_ADDR;
            wData_LDR       <= '0;
            done_LDR        <= 1'b0;
            error_LDR       <= 1'b0;
            wordsLoaded_LDR <= '0;
            byte_idx        <= '0;
            n_words         <= '0;
            acc             <= '0;
            asm_q           <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (take && byteIn_LDR == SYNC_BYTE) begin
                        state           <= COUNT;
                        cpuHold_LDR     <= 1'b1;
                        done_LDR        <= 1'b0;
                        error_LDR       <= 1'b0;
                        wordsLoaded_LDR <= '0;
                        acc             <= '0;
                        wAddr_LDR       <= BASE_ADDR;
                    end
                end
                COUNT: begin
                    if (take) begin
                        if (byteIn_LDR == 8'd0 || byteIn_LDR > MAX_N) begin
                            state     <= ERR;
                            error_LDR <= 1'b1;
                        end else begin
                            n_words  <= byteIn_LDR[6:0];
                            byte_idx <= '0;
                            state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (take) begin
                        asm_q    <= {asm_q[15:0], byteIn_LDR};
                        acc      <= acc + byteIn_LDR;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            wData_LDR     <= {asm_q, byteIn_LDR};
                            wEn_LDR       <= 1'b1;
                            byteReady_LDR <= 1'b0;
                            state         <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    // Single write cycle; address advance wraps naturally at 8 bits.
                    wEn_LDR         <= 1'b0;
                    byteReady_LDR   <= 1'b1;
                    wAddr_LDR       <= wAddr_LDR + 8'd4;
                    wordsLoaded_LDR <= wordsLoaded_LDR + 7'd1;
                    byte_idx        <= '0;
                    state           <= (wordsLoaded_LDR + 7'd1 == n_words) ? CHECK : DATA;
                end
                CHECK: begin
                    if (take) begin
                        if (byteIn_LDR == acc) begin
                            state       <= DONE;
                            done_LDR    <= 1'b1;
                            cpuHold_LDR <= 1'b0;
                        end else begin
                            state     <= ERR;
                            error_LDR <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: drives framed byte streams and checks
// the write log and status outputs against hand-computed values.
module tb_inst_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic        byteReady;
    logic        wEn;
    logic [7:0]  wAddr;
    logic [31:0] wData;
    logic        cpuHold;
    logic        done;
    logic        error;
    logic [6:0]  wordsLoaded;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  wa[$];
    logic [31:0] wd[$];

    always #5 clk = ~clk;

    inst_mem_loader dut (
        .clk_LDR        (clk),
        .rst_LDR        (rst),
        .byteIn_LDR     (byteIn),
        .byteValid_LDR  (byteValid),
        .byteReady_LDR  (byteReady),
        .wEn_LDR        (wEn),
        .wAddr_LDR      (wAddr),
        .wData_LDR      (wData),
        .cpuHold_LDR    (cpuHold),
        .done_LDR       (done),
        .error_LDR      (error),
        .wordsLoaded_LDR(wordsLoaded)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-port log, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (wEn === 1'b1) begin
            wa.push_back(wAddr);
            wd.push_back(wData);
            chk("ready_low_in_write", {31'b0, byteReady}, 32'd0);
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [7:0] b);
        int guard = 0;
        byteIn    = b;
        byteValid = 1'b1;
        while (byteReady !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) begin
            vectors++;
            miscompares++;
            $error("FAIL ready_timeout observed=0 expected=1");
        end
        @(negedge clk);
        byteValid = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic h, input logic d, input logic e);
        chk({tag, "_hold"}, {31'b0, cpuHold}, {31'b0, h});
        chk({tag, "_done"}, {31'b0, done}, {31'b0, d});
        chk({tag, "_err"},  {31'b0, error}, {31'b0, e});
    endtask

    logic [7:0]  frame_a[11] = '{8'hA5, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                                 8'h01, 8'h09, 8'h40, 8'h20, 8'h97};
    logic [31:0] ew[64];
    logic [7:0]  sum;
    logic [7:0]  b;

    initial begin
        rst = 1'b1; byteValid = 1'b0; byteIn = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, byteReady}, 32'd1);
        chk("rst_wen", {31'b0, wEn}, 32'd0);
        chk("rst_waddr", {24'b0, wAddr}, 32'h00);
        chk("rst_wdata", wData, 32'h0);
        chk("rst_words", {25'b0, wordsLoaded}, 32'd0);
        chk_status("rst", 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk_status("idle", 1'b1, 1'b0, 1'b0);
        chk("idle_ready", {31'b0, byteReady}, 32'd1);
        chk("idle_nowrite", wa.size(), 32'd0);

        // Good two-word frame, valid every cycle.
        for (int i = 0; i < 11; i++) send(frame_a[i]);
        chk_status("fa", 1'b0, 1'b1, 1'b0);
        chk("fa_words", {25'b0, wordsLoaded}, 32'd2);
        chk("fa_nwr", wa.size(), 32'd2);
        chk("fa_a0", {24'b0, wa[0]}, 32'h00);
        chk("fa_d0", wd[0], 32'h20080005);
        chk("fa_a1", {24'b0, wa[1]}, 32'h04);
        chk("fa_d1", wd[1], 32'h01094020);

        // Same frame, bad checksum; hold must rise on the sync edge.
        wa.delete(); wd.delete();
        send(8'hA5);
        chk_status("resync", 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) send(frame_a[i]);
        send(8'h98);
        chk_status("badck", 1'b1, 1'b0, 1'b1);
        chk("badck_nwr", wa.size(), 32'd2);
        chk("badck_d1", wd[1], 32'h01094020);

        // Junk then count 0, then a one-word zero frame.
        wa.delete(); wd.delete();
        send(8'h00); send(8'h33);
        chk_status("junk", 1'b1, 1'b0, 1'b1);
        send(8'hA5);
        chk("sync_clr_err", {31'b0, error}, 32'd0);
        send(8'h00);
        chk_status("cnt0", 1'b1, 1'b0, 1'b1);
        chk("cnt0_nwr", wa.size(), 32'd0);
        send(8'hA5); send(8'h01);
        repeat (5) send(8'h00);
        chk_status("zero", 1'b0, 1'b1, 1'b0);
        chk("zero_nwr", wa.size(), 32'd1);
        chk("zero_d0", wd[0], 32'h0);

        // Asynchronous reset mid-frame.
        wa.delete(); wd.delete();
        send(8'hA5); send(8'h02);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66);
        #2 rst = 1'b1;
        #1;
        chk_status("arst", 1'b1, 1'b0, 1'b0);
        chk("arst_waddr", {24'b0, wAddr}, 32'h00);
        chk("arst_wdata", wData, 32'h0);
        chk("arst_words", {25'b0, wordsLoaded}, 32'd0);
        chk("arst_ready", {31'b0, byteReady}, 32'd1);
        chk("arst_nwr", wa.size(), 32'd1);
        chk("arst_d0", wd[0], 32'h11223344);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wa.delete(); wd.delete();
        for (int i = 0; i < 11; i++) send(frame_a[i]);
        chk("restart_a0", {24'b0, wa[0]}, 32'h00);
        chk("restart_d1", wd[1], 32'h01094020);
        chk_status("restart", 1'b0, 1'b1, 1'b0);

        // Full 64-word frame with random idle gaps.
        wa.delete(); wd.delete();
        sum = 8'h00;
        send(8'hA5); send(8'd64);
        for (int w = 0; w < 64; w++) begin
            for (int j = 0; j < 4; j++) begin
                b = 8'(w * 7 + j * 61 + 3);
                ew[w][31 - 8*j -: 8] = b;
                sum = sum + b;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(b);
            end
        end
        send(sum);
        chk_status("full", 1'b0, 1'b1, 1'b0);
        chk("full_words", {25'b0, wordsLoaded}, 32'd64);
        chk("full_nwr", wa.size(), 32'd64);
        for (int w = 0; w < 64; w++) begin
            chk($sformatf("full_a%0d", w), {24'b0, wa[w]}, 32'(w * 4));
            chk($sformatf("full_d%0d", w), wd[w], ew[w]);
        end

        // Count above the limit.
        wa.delete(); wd.delete();
        send(8'hA5); send(8'd65);
        repeat (3) @(negedge clk);
        chk_status("n65", 1'b1, 1'b0, 1'b1);
        chk("n65_nwr", wa.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
